// File: rtl/run_stimulus_gen_pkg.sv
// Shared types and defaults for the run-length stimulus generator and its golden match counter.
package run_gen_pkg;

  localparam int LEN_W_DEF     = 4;
  localparam int MATCH_LEN_DEF = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_EMIT = EMIT;

  function automatic logic [1:0] state_to_onehot(input logic [0:0] st);
    return {st == ST_EMIT, st == ST_IDLE};
  endfunction

endpackage

// File: rtl/run_stimulus_gen_if.sv
// Run descriptor handshake: a producer offers {bit, length} and the generator accepts on valid & ready.
interface run_stimulus_gen_if
  import run_gen_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) ();

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic [LEN_W-1:0] in_len;

  modport master (output in_valid, output in_bit, output in_len, input in_ready);
  modport slave  (input in_valid, input in_bit, input in_len, output in_ready);

endinterface

// File: rtl/run_stimulus_gen_match_counter.sv
// Golden Moore model of a consecutive-equal-bit detector, fed with next-cycle W / w_valid.
// Z_exp rises one cycle after the MATCH_LEN-th equal bit is on W; no backpressure.
module run_match_counter
  import run_gen_pkg::*;
#(
  parameter int MATCH_LEN = MATCH_LEN_DEF
) (
  input  logic sys_clock,
  input  logic sys_reset,
  input  logic w_nxt,
  input  logic w_valid_nxt,
  output logic Z_exp
);

  localparam int                CNT_W   = $clog2(MATCH_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MATCH_LEN);

  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
  logic             z_q, z_d;

  always_comb begin
    w_d       = w_nxt;
    w_valid_d = w_valid_nxt;
    eq_cnt_d  = eq_cnt_q;
    if (!w_valid_nxt) begin
      eq_cnt_d = '0;
    end else if (!w_valid_q || (w_nxt != w_q)) begin
      eq_cnt_d = CNT_W'(1);
    end else if (eq_cnt_q != CNT_MAX) begin
      eq_cnt_d = eq_cnt_q + CNT_W'(1);
    end
    // Looks at the current cycle's count, so Z trails the completing bit by one cycle.
    z_d = (eq_cnt_q == CNT_MAX) & w_valid_q;
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      eq_cnt_q  <= '0;
      z_q       <= 1'b0;
    end else begin
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      eq_cnt_q  <= eq_cnt_d;
      z_q       <= z_d;
    end
  end

  assign Z_exp = z_q;

endmodule

// File: rtl/run_stimulus_gen.sv
// Serial run-length transmitter: descriptor accepted at edge k drives W from cycle k+1 for in_len cycles.
// Ready only when idle or on the last bit of a run, giving gap-free back-to-back runs.
module run_stimulus_gen
  import run_gen_pkg::*;
#(
  parameter int LEN_W     = LEN_W_DEF,
  parameter int MATCH_LEN = MATCH_LEN_DEF
) (
  input  logic                 sys_clock,
  input  logic                 sys_reset,
  run_stimulus_gen_if.slave    desc,
  output logic                 W,
  output logic                 w_valid,
  output logic                 Z_exp,
  output logic                 busy,
  output logic [1:0]           state_onehot
);

  localparam logic [LEN_W-1:0] REM_ONE = LEN_W'(1);

  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;

  logic rem_last;
  logic in_ready_c;
  logic load;

  assign rem_last   = (rem_q == REM_ONE);
  assign in_ready_c = (state_q == ST_IDLE) | ((state_q == ST_EMIT) & rem_last);
  assign desc.in_ready = in_ready_c;
  // A zero-length descriptor is consumed by the handshake but never loads a run.
  assign load       = desc.in_valid & in_ready_c & (desc.in_len != '0);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    w_d       = w_q;
    w_valid_d = w_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d   = ST_EMIT;
          rem_d     = desc.in_len;
          w_d       = desc.in_bit;
          w_valid_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (!rem_last) begin
          rem_d = rem_q - REM_ONE;
        end else if (load) begin
          rem_d = desc.in_len;
          w_d   = desc.in_bit;
        end else begin
          state_d   = ST_IDLE;
          rem_d     = '0;
          w_valid_d = 1'b0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rem_d     = '0;
        w_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clock or negedge sys_reset) begin
    if (!sys_reset) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
    end
  end

  run_match_counter #(
    .MATCH_LEN (MATCH_LEN)
  ) u_match (
    .sys_clock   (sys_clock),
    .sys_reset   (sys_reset),
    .w_nxt       (w_d),
    .w_valid_nxt (w_valid_d),
    .Z_exp       (Z_exp)
  );

  assign W            = w_q;
  assign w_valid      = w_valid_q;
  assign busy         = (state_q == ST_EMIT);
  assign state_onehot = state_to_onehot(state_q);

endmodule

// File: doc/run_stimulus_gen.md
# run_stimulus_gen

Serial run-length stimulus transmitter for the consecutive-bit detector: accepts run descriptors (bit value, run length) over a valid/ready handshake and drives the one-bit serial stream W, one bit per clock. It also produces Z_exp, a cycle-accurate golden copy of the detector's Moore output. The bench uses Z_exp to check the detector. Sits upstream of the detector on the W input, in the same sys_clock domain.

## Interface
- LEN_W, 4: width of run-length field; max run = 2^LEN_W-1
- MATCH_LEN, 4: consecutive equal bits that assert Z_exp; 2 ≤ MATCH_LEN ≤ 2^LEN_W-1
- sys_clock  in  1  clock, rising edge
- sys_reset  in  1  asynchronous, active-low reset
- in_valid  in  1  descriptor valid
- in_ready  out  1  descriptor accepted when in_valid & in_ready at a rising edge
- in_bit  in  1  bit value of the run
- in_len  in  LEN_W  run length in bits; 0 allowed
- W  out  1  serial stream to detector, registered
- w_valid  out  1  W carries a run bit this cycle, registered
- Z_exp  out  1  expected detector output, registered
- busy  out  1  state == EMIT
- state_onehot  out  2  {EMIT, IDLE} one-hot

## Operation
- States: IDLE, EMIT. Reset → IDLE.
- Registers: run_bit, rem (LEN_W bits, bits still to show including current), eq_cnt (saturating at MATCH_LEN), W, w_valid, Z_exp.
- in_ready = (state==IDLE) | (state==EMIT & rem==1). Combinational from state/rem only; it never depends on in_valid.
- IDLE, accept with in_len>0: → EMIT; rem←in_len; W←in_bit; w_valid←1.
- IDLE, accept with in_len==0: descriptor is consumed; the block stays IDLE and emits no bits.
- EMIT, rem>1: rem←rem-1; W held.
- EMIT, rem==1, accept with in_len>0: rem←in_len; W←in_bit; state stays EMIT. This is a zero-bubble transition.
- EMIT, rem==1, no accept or in_len==0: → IDLE; w_valid←0; W holds last value.
- Golden model, updated every edge:
  - If the next w_valid is 0: eq_cnt←0.
  - Else if this is the first valid bit after a gap, or the next W differs from the current W: eq_cnt←1.
  - Else: eq_cnt←min(eq_cnt+1, MATCH_LEN).
- Equal bits chain across descriptor boundaries. Example: 2×'1' then 3×'1' is a run of 5.
- Z_exp←(eq_cnt==MATCH_LEN) & w_valid, registered. It therefore rises the cycle after the MATCH_LEN-th equal bit is on W, matching the Moore detector's registered state.
- An idle gap (w_valid=0) resets the run. After a gap, the detector must be reset by the bench before the next sequence is checked.

## Timing
- Reset values: state=IDLE, state_onehot=2'b01, in_ready=1, W=0, w_valid=0, Z_exp=0, busy=0, rem=0, eq_cnt=0.
- Latency: descriptor accepted at edge k → first bit on W in cycle k+1. The run occupies cycles k+1 … k+in_len.
- Throughput: one bit per cycle sustained with back-to-back descriptors.
- Z_exp latency: W bit n, being the MATCH_LEN-th equal bit, is on W in cycle c → Z_exp=1 in cycle c+1. Z_exp stays 1 while equal bits continue. It drops the cycle after the first differing bit or the first w_valid=0 cycle.
- Reset mid-run: asserting sys_reset immediately forces all outputs to their reset values. The descriptor in flight is discarded. No handshake occurs during reset.
- Descriptor fields are sampled only at the accepting edge; changes at other times are ignored.

## Structure
- Package run_gen_pkg: state enum typedef (IDLE, EMIT), default constants LEN_W_DEF=4 and MATCH_LEN_DEF=4.
- Sub-module run_match_counter: eq_cnt and Z_exp golden logic. Inputs: next W, next w_valid. Output: Z_exp. It is reusable by other detector benches.
- Top: handshake, FSM, rem counter, output registers.

## Test plan
- Reset, then descriptor (0, 5) → W=0 for 5 cycles; Z_exp=1 in cycles 5 and 6 after accept; w_valid=0 after cycle 5.
- Back-to-back (1, 2), (1, 3) with in_valid held → 5 contiguous 1s, no bubble; in_ready=1 only in IDLE and rem==1 cycles; Z_exp rises after the 4th 1.
- Alternating (0, 3), (1, 3), (0, 3) → 9 contiguous bits; Z_exp never asserts.
- (1, 0) followed by (1, 4) → the zero-length descriptor emits nothing; 4 ones follow; Z_exp=1 one cycle after the 4th.
- (0, 15), reset pulsed at bit 7 → all outputs return to reset values asynchronously; after release, in_ready=1 and no residual bits are emitted.
- Loopback with the detector, 500 random descriptors, detector reset at each gap → detector Z equals Z_exp on every cycle.
